// File: rtl/hdc_pkg.sv
// HDC inference sequencer shared types and defaults.
// Cycle-count helper matches the control FSM's state walk.
package hdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_MAP_REQ,
    S_MAP_WAIT,
    S_BUNDLE,
    S_SEARCH,
    S_DONE,
    S_ERR
  } state_t;

  localparam int NUM_FEATURES_DEF = 16;
  localparam int NUM_CLASSES_DEF  = 10;

  function automatic int seq_cycles(int nf, int nc, int w);
    return 2 + nf * (2 + w) + nc;
  endfunction

  localparam int SEQ_CYCLE_COUNT =
    seq_cycles(NUM_FEATURES_DEF, NUM_CLASSES_DEF, 1);

endpackage

// File: rtl/hdc_argmax.sv
// Running-maximum tracker for the associative search.
// First class loads unconditionally; ties keep the earlier index.
module hdc_argmax #(
  parameter int SCORE_W = 10,
  parameter int IW      = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               upd_i,
  input  logic               first_i,
  input  logic [IW-1:0]      idx_i,
  input  logic [SCORE_W-1:0] score_i,
  output logic [IW-1:0]      best_idx_o
);

  logic [SCORE_W-1:0] best_q;
  logic [IW-1:0]      idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_q <= '0;
      idx_q  <= '0;
    end else if (upd_i && (first_i || score_i > best_q)) begin
      best_q <= score_i;
      idx_q  <= idx_i;
    end
  end

  assign best_idx_o = idx_q;

endmodule

// File: rtl/hdc_seq_ctrl.sv
// HDC inference sequencer: clear, map/bundle each feature, argmax search.
// Optional mapping watchdog enabled by HDC_WATCHDOG_EN.
module hdc_seq_ctrl
  import hdc_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int NUM_CLASSES  = NUM_CLASSES_DEF,
  parameter int SCORE_W      = 10,
  parameter int WDOG_CYCLES  = 64,
  localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  output logic               busy,
  output logic               map_start,
  input  logic               map_done,
  output logic               bundle_clr,
  output logic               bundle_en,
  output logic [FW-1:0]      feat_idx,
  output logic               search_en,
  output logic [CW-1:0]      class_idx,
  input  logic [SCORE_W-1:0] sim_score,
  output logic               result_valid,
  output logic [CW-1:0]      result_class,
  input  logic               result_ack,
  output logic               err
);

  state_t        state_q, state_d;
  logic [FW-1:0] feat_q, feat_d;
  logic [CW-1:0] class_q, class_d;
  logic          busy_q, clr_q, mstart_q, ben_q, sen_q, rv_q;

`ifdef HDC_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q;
`endif

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    class_d = class_q;
`ifdef HDC_WATCHDOG_EN
    wdog_d  = wdog_q;
`endif
    if (en) begin
      unique case (state_q)
        S_IDLE:     if (start) state_d = S_CLR;
        S_CLR: begin
          feat_d  = '0;
          state_d = S_MAP_REQ;
        end
        S_MAP_REQ: begin
          state_d = S_MAP_WAIT;
`ifdef HDC_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end
        S_MAP_WAIT: begin
          if (map_done) state_d = S_BUNDLE;
`ifdef HDC_WATCHDOG_EN
          else if (wdog_q == WW'(WDOG_CYCLES - 1)) state_d = S_ERR;
          else wdog_d = wdog_q + WW'(1);
`endif
        end
        S_BUNDLE: begin
          if (feat_q == FW'(NUM_FEATURES - 1)) begin
            state_d = S_SEARCH;
            class_d = '0;
          end else begin
            feat_d  = feat_q + FW'(1);
            state_d = S_MAP_REQ;
          end
        end
        S_SEARCH: begin
          if (class_q == CW'(NUM_CLASSES - 1)) state_d = S_DONE;
          else class_d = class_q + CW'(1);
        end
        S_DONE:     if (result_ack) state_d = S_IDLE;
        S_ERR:      state_d = S_ERR;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      feat_q   <= '0;
      class_q  <= '0;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
      mstart_q <= 1'b0;
      ben_q    <= 1'b0;
      sen_q    <= 1'b0;
      rv_q     <= 1'b0;
`ifdef HDC_WATCHDOG_EN
      wdog_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      class_q  <= class_d;
      busy_q   <= (state_d != S_IDLE);
      clr_q    <= (state_d == S_CLR);
      mstart_q <= (state_d == S_MAP_REQ);
      ben_q    <= (state_d == S_BUNDLE);
      sen_q    <= (state_d == S_SEARCH);
      rv_q     <= (state_d == S_DONE);
`ifdef HDC_WATCHDOG_EN
      wdog_q   <= wdog_d;
      err_q    <= (state_d == S_ERR);
`endif
    end
  end

  assign busy         = busy_q;
  assign bundle_clr   = clr_q & en;
  assign map_start    = mstart_q & en;
  assign bundle_en    = ben_q & en;
  assign search_en    = sen_q & en;
  assign result_valid = rv_q;
  assign feat_idx     = feat_q;
  assign class_idx    = class_q;

`ifdef HDC_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  hdc_argmax #(
    .SCORE_W (SCORE_W),
    .IW      (CW)
  ) u_argmax (
    .clk_i      (clk),
    .rst_i      (rst),
    .upd_i      (search_en),
    .first_i    (class_q == '0),
    .idx_i      (class_q),
    .score_i    (sim_score),
    .best_idx_o (result_class)
  );

endmodule
